// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter with wormhole grant lock.
// Optional stall watchdog enabled by defining AXIS_PKT_ARB_WATCHDOG_EN.
module axis_pkt_rr_arbiter #(
    parameter int WIDTH           = 64,
    parameter int NUM_INPUTS      = 4,
    parameter int WD_TIMEOUT_LOG2 = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [WIDTH*NUM_INPUTS-1:0]     s_axis_tdata,
    input  logic [NUM_INPUTS-1:0]           s_axis_tlast,
    input  logic [NUM_INPUTS-1:0]           s_axis_tvalid,
    output logic [NUM_INPUTS-1:0]           s_axis_tready,
    output logic [WIDTH-1:0]                m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            active,
    output logic [$clog2(NUM_INPUTS)-1:0]   cur_port,
    output logic [31:0]                     pkt_count,
    output logic                            deadlock_detected
);

    localparam int PW = $clog2(NUM_INPUTS);
    localparam logic [PW:0] NUM_W = (PW+1)'(NUM_INPUTS);

    typedef enum logic {IDLE, PASS} state_t;

    state_t        state;
    logic [PW-1:0] last_port;
    logic [PW-1:0] next_port;
    logic          req_found;
    logic          handshake;
    logic [PW:0]   scan_idx;

    // Round-robin scan starting just after the last port that completed a packet.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        next_port = '0;
        req_found = 1'b0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            scan_idx = {1'b0, last_port} + (PW+1)'(k);
            if (scan_idx >= NUM_W)
                scan_idx = scan_idx - NUM_W;
            if (!req_found && s_axis_tvalid[scan_idx[PW-1:0]]) begin
                req_found = 1'b1;
                next_port = scan_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (state == PASS) begin
            m_axis_tdata            = s_axis_tdata[int'(cur_port)*WIDTH +: WIDTH];
            m_axis_tlast            = s_axis_tlast[cur_port];
            m_axis_tvalid           = s_axis_tvalid[cur_port];
            s_axis_tready[cur_port] = m_axis_tready;
        end
    end

    assign handshake = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_port  <= '0;
            last_port <= PW'(NUM_INPUTS-1);
            active    <= 1'b0;
            pkt_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            case (state)
                IDLE: begin
                    if (req_found) begin
                        cur_port <= next_port;
                        state    <= PASS;
                        active   <= 1'b1;
                    end
                end
                PASS: begin
                    if (handshake && m_axis_tlast) begin
                        last_port <= cur_port;
                        pkt_count <= pkt_count + 32'd1;
                        state     <= IDLE;
                        active    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXIS_PKT_ARB_WATCHDOG_EN
    logic [WD_TIMEOUT_LOG2-1:0] wd_cnt;
    logic [WD_TIMEOUT_LOG2-1:0] wd_next;
    logic                       wd_flag;

    // Saturating count of stalled cycles while a grant is held.
    always_comb begin
        wd_next = (&wd_cnt) ? wd_cnt : wd_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else if (state != PASS || handshake) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else begin
            wd_cnt  <= wd_next;
            wd_flag <= &wd_next;
        end
    end

    assign deadlock_detected = wd_flag;
`else
    assign deadlock_detected = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Self-checking bench for axis_pkt_rr_arbiter: vector table, corner sequences,
// and randomized traffic against a packet-level reference model.
module tb_axis_pkt_rr_arbiter;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int PW = 2;
`ifdef AXIS_PKT_ARB_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [W*N-1:0] s_axis_tdata;
    logic [N-1:0]   s_axis_tlast;
    logic [N-1:0]   s_axis_tvalid;
    logic [N-1:0]   s_axis_tready;
    logic [W-1:0]   m_axis_tdata;
    logic           m_axis_tlast;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic           active;
    logic [PW-1:0]  cur_port;
    logic [31:0]    pkt_count;
    logic           deadlock_detected;

    int vectors     = 0;
    int miscompares = 0;

    axis_pkt_rr_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .active            (active),
        .cur_port          (cur_port),
        .pkt_count         (pkt_count),
        .deadlock_detected (deadlock_detected)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pat(input int port, input int tag);
        return {32'hA5A5_0000 | 32'(port), 32'(tag)};
    endfunction

    task automatic set_data(input int tag);
        for (int i = 0; i < N; i++) s_axis_tdata[i*W +: W] = pat(i, tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        set_data(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  last;
        logic          mready;
        logic [N-1:0]  e_tready;
        logic          e_mvalid;
        logic          e_mlast;
        logic          e_active;
        logic [PW-1:0] e_cur;
        logic [31:0]   e_pkt;
    } vec_t;

    vec_t tbl[15];

    // Random-phase reference model: packet-level arbiter state.
    int busy, owner, lastp, cnt;
    int seq[N], pos[N], len[N];

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            s_axis_tvalid[i] = ($urandom_range(99) < 60);
            s_axis_tlast[i]  = (pos[i] == len[i] - 1);
            s_axis_tdata[i*W +: W] = pat(i, seq[i]);
        end
        m_axis_tready = ($urandom_range(99) < 75);
    endtask

    initial begin
        logic [N-1:0] hs_mask;
        logic [N-1:0] beat;
        int order[$];
        int idle_between, done, cyc, hs3;
        logic found;
        int p;

        // Port 2 alone sends 3 beats, then port 1 holds 5 beats against port 0.
        tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0};
        tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0};
        tbl[2]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 32'd0};
        tbl[3]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 32'd0};
        tbl[4]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 32'd0};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 32'd1};
        tbl[6]  = '{4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 32'd1};
        tbl[7]  = '{4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 32'd1};
        tbl[8]  = '{4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 32'd1};
        tbl[9]  = '{4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 32'd1};
        tbl[10] = '{4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 32'd1};
        tbl[11] = '{4'b0011, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 32'd1};
        tbl[12] = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 32'd2};
        tbl[13] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 32'd2};
        tbl[14] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd3};

        do_reset();
        check("rst_tready", s_axis_tready, 0);
        check("rst_mvalid", m_axis_tvalid, 0);
        check("rst_mdata", m_axis_tdata, 0);
        check("rst_active", active, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_wd", deadlock_detected, 0);

        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            s_axis_tvalid = tbl[k].valid;
            s_axis_tlast  = tbl[k].last;
            m_axis_tready = tbl[k].mready;
            set_data(k);
            @(negedge clk);
            check($sformatf("v%0d_tready", k), s_axis_tready, tbl[k].e_tready);
            check($sformatf("v%0d_mvalid", k), m_axis_tvalid, tbl[k].e_mvalid);
            check($sformatf("v%0d_mlast", k), m_axis_tlast, tbl[k].e_mlast);
            check($sformatf("v%0d_active", k), active, tbl[k].e_active);
            check($sformatf("v%0d_cur", k), cur_port, tbl[k].e_cur);
            check($sformatf("v%0d_pkt", k), pkt_count, tbl[k].e_pkt);
            check($sformatf("v%0d_mdata", k), m_axis_tdata,
                  tbl[k].e_active ? pat(int'(tbl[k].e_cur), k) : 64'd0);
        end

        // Fairness: all ports stream 2-beat packets continuously.
        do_reset();
        m_axis_tready = 1'b1;
        s_axis_tvalid = '1;
        s_axis_tlast  = '0;
        beat = '0;
        idle_between = 0; done = 0; cyc = 0;
        while (done < 12 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done > 0 && !active) idle_between++;
            hs_mask = s_axis_tvalid & s_axis_tready;
            for (int i = 0; i < N; i++)
                if (hs_mask[i] && s_axis_tlast[i]) begin
                    order.push_back(i);
                    done++;
                end
            @(posedge clk); #1;
            beat = beat ^ hs_mask;
            s_axis_tlast = beat;
        end
        check("fair_done", done, 12);
        check("fair_idle", idle_between, 11);
        check("fair_pkt", pkt_count, 12);
        for (int j = 0; j < 12; j++)
            check($sformatf("fair_order%0d", j), (j < order.size()) ? order[j] : -1, j % N);
        s_axis_tvalid = '0;

        // Watchdog: stall downstream mid-packet for 1023 cycles.
        do_reset();
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid = 4'b0001;
        s_axis_tlast  = 4'b0000;
        @(posedge clk);
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        for (int k = 1; k <= 1023; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1022) check("wd_early", deadlock_detected, 0);
            if (k == 1023) check("wd_hit", deadlock_detected, WD);
        end
        check("wd_hold_active", active, 1);
        m_axis_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("wd_clear", deadlock_detected, 0);
        s_axis_tlast = 4'b0001;
        @(posedge clk); #1;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        @(negedge clk);
        check("wd_end_active", active, 0);
        check("wd_end_pkt", pkt_count, 1);

        // Reset asserted on the second beat of a port-1 packet.
        do_reset();
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid = 4'b0001;
        s_axis_tlast  = 4'b0001;
        @(posedge clk);
        @(posedge clk); #1;
        s_axis_tvalid = 4'b0010;
        s_axis_tlast  = 4'b0000;
        @(negedge clk);
        check("mid_pkt_before", pkt_count, 1);
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_active", active, 1);
        reset = 1'b1;
        #1;
        check("arst_tready", s_axis_tready, 0);
        check("arst_mvalid", m_axis_tvalid, 0);
        check("arst_active", active, 0);
        check("arst_pkt", pkt_count, 0);
        @(negedge clk);
        reset = 1'b0;
        s_axis_tvalid = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_cur", cur_port, 0);
        check("post_rst_tready", s_axis_tready, 4'b0001);

        // Port 3 single-beat packets back-to-back, then port 0 joins.
        do_reset();
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid = 4'b1000;
        s_axis_tlast  = 4'b1000;
        @(posedge clk);
        hs3 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (s_axis_tvalid[3] && s_axis_tready[3]) hs3++;
            @(posedge clk);
        end
        check("p3_rate", hs3, 5);
        #1;
        s_axis_tvalid = 4'b1001;
        s_axis_tlast  = 4'b1001;
        @(negedge clk);
        check("p3_cur", cur_port, 3);
        @(posedge clk);
        @(negedge clk);
        check("p3_bubble", active, 0);
        @(posedge clk);
        @(negedge clk);
        check("p0_after_p3", cur_port, 0);
        check("p0_tready", s_axis_tready, 4'b0001);

        // Randomized traffic against the packet-level model.
        do_reset();
        busy = 0; owner = 0; lastp = N - 1; cnt = 0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; pos[i] = 0; len[i] = $urandom_range(4, 1);
        end
        @(posedge clk); #1;
        drive_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("rnd_active", active, busy);
            check("rnd_cur", cur_port, owner);
            check("rnd_pkt", pkt_count, cnt);
            check("rnd_mvalid", m_axis_tvalid, (busy != 0) && s_axis_tvalid[owner]);
            check("rnd_mdata", m_axis_tdata, busy ? pat(owner, seq[owner]) : 64'd0);
            check("rnd_mlast", m_axis_tlast, (busy != 0) && s_axis_tlast[owner]);
            check("rnd_tready", s_axis_tready,
                  (busy && m_axis_tready) ? (4'b0001 << owner) : 4'b0000);
            check("rnd_wd", deadlock_detected, 0);
            @(posedge clk);
            if (!busy) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    p = (lastp + k) % N;
                    if (!found && s_axis_tvalid[p]) begin
                        found = 1'b1;
                        owner = p;
                        busy  = 1;
                    end
                end
            end else if (s_axis_tvalid[owner] && m_axis_tready) begin
                seq[owner]++;
                if (s_axis_tlast[owner]) begin
                    pos[owner] = 0;
                    len[owner] = $urandom_range(4, 1);
                    busy  = 0;
                    lastp = owner;
                    cnt++;
                end else begin
                    pos[owner]++;
                end
            end
            #1;
            drive_random();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
